// File: rtl/fc_feeder_if.sv
// Handshake bundle between fc_feeder, its loader/controller and the FC neuron block.
interface fc_feeder_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned AW     = 5
);
    logic              wr_en;
    logic              wr_sel;
    logic [AW-1:0]     wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              start;
    logic              reuse_w;
    logic              load_weight;
    logic [DATA_W-1:0] weight;
    logic              valid_in;
    logic [DATA_W-1:0] data_in;
    logic              load_weight_done;
    logic              valid_out;
    logic [DATA_W-1:0] feature;
    logic [DATA_W-1:0] result;
    logic              busy;
    logic              done;
    logic              err;

    modport slave (
        input  wr_en, wr_sel, wr_addr, wr_data, start, reuse_w,
               load_weight_done, valid_out, feature,
        output load_weight, weight, valid_in, data_in, result, busy, done, err
    );

    modport master (
        output wr_en, wr_sel, wr_addr, wr_data, start, reuse_w,
               load_weight_done, valid_out, feature,
        input  load_weight, weight, valid_in, data_in, result, busy, done, err
    );
endinterface

// File: rtl/fc_feeder.sv
// Initiator-side sequencer for one FC neuron: streams weights+bias, then features, captures the result.
// Optional watchdog on the wait states is enabled by defining FC_FEEDER_TIMEOUT_EN.
module fc_feeder #(
    parameter int unsigned N_IN    = 16,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned AW      = 5,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset,
    fc_feeder_if.slave  bus
);
    localparam int unsigned WW = $clog2(N_IN + 1);
    localparam int unsigned FW = $clog2(N_IN);
    localparam int unsigned CW = $clog2(N_IN + 2);
    localparam int unsigned TW = $clog2(TIMEOUT);

    if ((1 << AW) < N_IN + 1) begin : g_aw_check
        $error("fc_feeder: AW too narrow for N_IN+1 weight words");
    end
    if (TIMEOUT < 2) begin : g_tmo_check
        $error("fc_feeder: TIMEOUT must be at least 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_WAIT_WD,
        S_GAP,
        S_SEND,
        S_WAIT_OUT,
        S_DONE
    } state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic              load_weight_q;
    logic [DATA_W-1:0] weight_q;
    logic              valid_in_q;
    logic [DATA_W-1:0] data_in_q;
    logic [DATA_W-1:0] result_q;
    logic              busy_q;
    logic              done_q;

    logic [DATA_W-1:0] wmem [N_IN+1];
    logic [DATA_W-1:0] fmem [N_IN];

    // Loader writes; frozen while a sequence is in flight, out-of-range addresses dropped
    always_ff @(posedge clk) begin
        if (bus.wr_en && !busy_q) begin
            if (!bus.wr_sel && (32'(bus.wr_addr) < N_IN + 1))
                wmem[WW'(bus.wr_addr)] <= bus.wr_data;
            if (bus.wr_sel && (32'(bus.wr_addr) < N_IN))
                fmem[FW'(bus.wr_addr)] <= bus.wr_data;
        end
    end

`ifdef FC_FEEDER_TIMEOUT_EN
    logic          err_q;
    logic [TW-1:0] wd_cnt;
`endif

    // Sequencer; outputs are registered and set up on the edge that enters each state
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            cnt           <= '0;
            load_weight_q <= 1'b0;
            weight_q      <= '0;
            valid_in_q    <= 1'b0;
            data_in_q     <= '0;
            result_q      <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
`ifdef FC_FEEDER_TIMEOUT_EN
            err_q         <= 1'b0;
            wd_cnt        <= '0;
`endif
        end else begin
`ifdef FC_FEEDER_TIMEOUT_EN
            wd_cnt <= '0;
`endif
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        busy_q <= 1'b1;
`ifdef FC_FEEDER_TIMEOUT_EN
                        err_q  <= 1'b0;
`endif
                        if (bus.reuse_w) begin
                            state <= S_GAP;
                        end else begin
                            state         <= S_LOAD_W;
                            load_weight_q <= 1'b1;
                            weight_q      <= wmem[0];
                            cnt           <= CW'(1);
                        end
                    end
                end
                S_LOAD_W: begin
                    if (cnt == CW'(N_IN + 1)) begin
                        state         <= S_WAIT_WD;
                        load_weight_q <= 1'b0;
                        weight_q      <= '0;
                        cnt           <= '0;
                    end else begin
                        weight_q <= wmem[WW'(cnt)];
                        cnt      <= cnt + CW'(1);
                    end
                end
                S_WAIT_WD: begin
                    if (bus.load_weight_done) begin
                        state <= S_GAP;
                    end
`ifdef FC_FEEDER_TIMEOUT_EN
                    else if (wd_cnt == TW'(TIMEOUT - 1)) begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                        err_q  <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + TW'(1);
                    end
`endif
                end
                S_GAP: begin
                    state      <= S_SEND;
                    valid_in_q <= 1'b1;
                    data_in_q  <= fmem[0];
                    cnt        <= CW'(1);
                end
                S_SEND: begin
                    if (cnt == CW'(N_IN)) begin
                        state      <= S_WAIT_OUT;
                        valid_in_q <= 1'b0;
                        data_in_q  <= '0;
                        cnt        <= '0;
                    end else begin
                        data_in_q <= fmem[FW'(cnt)];
                        cnt       <= cnt + CW'(1);
                    end
                end
                S_WAIT_OUT: begin
                    if (bus.valid_out) begin
                        state    <= S_DONE;
                        result_q <= bus.feature;
                        done_q   <= 1'b1;
                    end
`ifdef FC_FEEDER_TIMEOUT_EN
                    else if (wd_cnt == TW'(TIMEOUT - 1)) begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                        err_q  <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + TW'(1);
                    end
`endif
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.load_weight = load_weight_q;
    assign bus.weight      = weight_q;
    assign bus.valid_in    = valid_in_q;
    assign bus.data_in     = data_in_q;
    assign bus.result      = result_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
`ifdef FC_FEEDER_TIMEOUT_EN
    assign bus.err         = err_q;
`else
    assign bus.err         = 1'b0;
`endif
endmodule

// File: tb/tb_fc_feeder.sv
// Directed bench for fc_feeder: cycle-exact checks of weight/feature streaming and result capture.
module tb_fc_feeder;
    localparam int unsigned N_IN   = 16;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned AW     = 5;
`ifdef FC_FEEDER_TIMEOUT_EN
    localparam int unsigned TMO    = 32;
`else
    localparam int unsigned TMO    = 1024;
`endif

    logic clk = 1'b0;
    logic reset;
    int   n_total = 0;
    int   n_pass  = 0;
    logic [31:0] exp_result = '0;

    always #5 clk = ~clk;

    fc_feeder_if #(.DATA_W(DATA_W), .AW(AW)) bus ();

    fc_feeder #(
        .N_IN(N_IN), .DATA_W(DATA_W), .AW(AW), .TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_lw"},   32'(bus.load_weight), 32'd0);
        check({tag, "_w"},    bus.weight,           32'd0);
        check({tag, "_vi"},   32'(bus.valid_in),    32'd0);
        check({tag, "_din"},  bus.data_in,          32'd0);
    endtask

    task automatic wr(input logic sel, input int addr, input logic [31:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_sel  = sel;
        bus.wr_addr = AW'(addr);
        bus.wr_data = data;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    // One inference with the FC side played by hand-placed strobes
    task automatic run(input logic reuse, input int wd_delay, input int out_delay,
                       input logic [31:0] val, input logic disturb, input logic do_reset);
        bus.start   = 1'b1;
        bus.reuse_w = reuse;
        tick();
        bus.start   = 1'b0;
        bus.reuse_w = 1'b0;
        check("busy_after_start", 32'(bus.busy), 32'd1);
        check("err_after_start",  32'(bus.err),  32'd0);
        if (!reuse) begin
            for (int i = 0; i <= int'(N_IN); i++) begin
                check("lw_stream", 32'(bus.load_weight), 32'd1);
                check("weight",    bus.weight,           32'(i + 1));
                check("vi_in_lw",  32'(bus.valid_in),    32'd0);
                tick();
            end
            for (int k = 0; k <= wd_delay; k++) begin
                check_quiet("wait_wd");
                check("wait_wd_busy", 32'(bus.busy), 32'd1);
                if (k == wd_delay) bus.load_weight_done = 1'b1;
                tick();
            end
            bus.load_weight_done = 1'b0;
        end
        check_quiet("gap");
        tick();
        for (int j = 0; j < int'(N_IN); j++) begin
            check("vi_stream", 32'(bus.valid_in),    32'd1);
            check("data_in",   bus.data_in,          32'h10 + 32'(j));
            check("lw_in_send", 32'(bus.load_weight), 32'd0);
            if (do_reset && j == 7) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
                exp_result = '0;
                check_quiet("post_reset");
                check("post_reset_busy",   32'(bus.busy), 32'd0);
                check("post_reset_done",   32'(bus.done), 32'd0);
                check("post_reset_result", bus.result,    32'd0);
                tick();
                check("post_reset_idle_vi", 32'(bus.valid_in), 32'd0);
                return;
            end
            if (disturb && j == 3) begin
                bus.wr_en = 1'b1; bus.wr_sel = 1'b0; bus.wr_addr = '0; bus.wr_data = 32'hFFFF;
                bus.start = 1'b1;
                bus.valid_out = 1'b1; bus.feature = 32'h1234_5678;
            end else if (disturb && j == 4) begin
                bus.wr_sel = 1'b1;
                bus.reuse_w = 1'b1;
            end else begin
                bus.wr_en = 1'b0; bus.start = 1'b0; bus.reuse_w = 1'b0;
                bus.valid_out = 1'b0; bus.feature = '0;
            end
            tick();
        end
        for (int k = 0; k <= out_delay; k++) begin
            check_quiet("wait_out");
            check("wait_out_done",   32'(bus.done), 32'd0);
            check("wait_out_result", bus.result,    exp_result);
            if (k == out_delay) begin
                bus.valid_out = 1'b1;
                bus.feature   = val;
            end
            tick();
        end
        bus.valid_out = 1'b0;
        bus.feature   = '0;
        exp_result    = val;
        check("done_pulse",   32'(bus.done), 32'd1);
        check("result",       bus.result,    val);
        check("busy_in_done", 32'(bus.busy), 32'd1);
        tick();
        check("done_cleared", 32'(bus.done), 32'd0);
        check("busy_cleared", 32'(bus.busy), 32'd0);
        check("result_held",  bus.result,    val);
    endtask

    initial begin
        reset = 1'b1;
        bus.wr_en = 1'b0; bus.wr_sel = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.start = 1'b0; bus.reuse_w = 1'b0;
        bus.load_weight_done = 1'b0; bus.valid_out = 1'b0; bus.feature = '0;
        tick();
        tick();
        check_quiet("reset");
        check("reset_result", bus.result,     32'd0);
        check("reset_busy",   32'(bus.busy),  32'd0);
        check("reset_done",   32'(bus.done),  32'd0);
        check("reset_err",    32'(bus.err),   32'd0);
        reset = 1'b0;
        tick();

        for (int i = 0; i <= int'(N_IN); i++) wr(1'b0, i, 32'(i + 1));
        for (int j = 0; j < int'(N_IN); j++)  wr(1'b1, j, 32'h10 + 32'(j));
        wr(1'b1, 16, 32'h0BAD);
        check("idle_quiet_vi", 32'(bus.valid_in), 32'd0);

        run(1'b0, 2, 5, 32'hDEAD_BEEF, 1'b0, 1'b0);
        run(1'b1, 0, 0, 32'hCAFE_F00D, 1'b1, 1'b0);
        run(1'b0, 2, 3, 32'h1111_1111, 1'b0, 1'b0);
        run(1'b0, 1, 0, 32'h0,         1'b0, 1'b1);
        run(1'b0, 0, 2, 32'h2222_2222, 1'b0, 1'b0);

`ifdef FC_FEEDER_TIMEOUT_EN
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i <= int'(N_IN); i++) begin
            check("tmo_weight", bus.weight, 32'(i + 1));
            tick();
        end
        for (int k = 0; k < int'(TMO); k++) begin
            check("tmo_err_low", 32'(bus.err),      32'd0);
            check("tmo_busy",    32'(bus.busy),     32'd1);
            check("tmo_vi",      32'(bus.valid_in), 32'd0);
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            check("tmo_err_set", 32'(bus.err),      32'd1);
            check("tmo_idle",    32'(bus.busy),     32'd0);
            check("tmo_no_done", 32'(bus.done),     32'd0);
            check("tmo_vi_idle", 32'(bus.valid_in), 32'd0);
            check("tmo_result",  bus.result,        exp_result);
            tick();
        end
        run(1'b1, 0, 1, 32'h3333_3333, 1'b0, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/fc_feeder.md
# fc_feeder

Sequencer that drives the FC layer's load/stream protocol from the initiator side. It holds one bias/weight set and one flattened feature vector in local register files, plays weights then features into the FC block with the exact `load_weight` / `valid_in` cadence that block expects, and captures the returned `feature` word. It sits between the maxpool output buffer / host loader and `full_connected_16`, one instance per FC neuron.

## Interface
- `N_IN`, 16: feature count (WIDTH*HEIGHT after maxpool); weight memory holds N_IN+1 words (N_IN weights, then bias).
- `DATA_W`, 32: word width of weights, features and result.
- `AW`, 5: write-address width; must satisfy 2^AW ≥ N_IN+1.
- `TIMEOUT`, 1024: watchdog limit in cycles for each wait state (only with `FC_FEEDER_TIMEOUT_EN`).

- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `wr_en`  in  1  loader write strobe.
- `wr_sel`  in  1  0 = weight/bias memory, 1 = feature memory.
- `wr_addr`  in  AW  word address.
- `wr_data`  in  DATA_W  word to store.
- `start`  in  1  begin one inference, sampled in IDLE only.
- `reuse_w`  in  1  sampled with `start`; 1 = skip weight load.
- `load_weight`  out  1  to FC: weight stream active.
- `weight`  out  DATA_W  to FC: current weight/bias word.
- `valid_in`  out  1  to FC: feature word valid.
- `data_in`  out  DATA_W  to FC: current feature word.
- `load_weight_done`  in  1  from FC: weight load acknowledged.
- `valid_out`  in  1  from FC: `feature` valid this cycle.
- `feature`  in  DATA_W  from FC: neuron result.
- `result`  out  DATA_W  captured `feature`, held until next capture.
- `busy`  out  1  high from first cycle after accepted `start` through `done` cycle.
- `done`  out  1  one-cycle pulse, result valid.
- `err`  out  1  sticky watchdog flag, cleared by `reset` or next accepted `start`.

## Operation
- Reset: state IDLE, all counters 0; `load_weight`, `valid_in`, `busy`, `done`, `err` = 0; `weight`, `data_in`, `result` = 0. Memories are not cleared.
- Writes: accepted only when not `busy`; ignored while `busy` or when address exceeds range (≥ N_IN+1 for `wr_sel`=0, ≥ N_IN for `wr_sel`=1).
- FSM states:
  - IDLE: `start`=1 → LOAD_W (or GAP if `reuse_w`=1); latch `err`←0.
  - LOAD_W: `load_weight`=1, `weight`=wmem[i], i=0..N_IN; after i=N_IN → WAIT_WD.
  - WAIT_WD: `load_weight`=0; `load_weight_done`=1 → GAP.
  - GAP: exactly one idle cycle, both strobes 0.
  - SEND: `valid_in`=1, `data_in`=fmem[j], j=0..N_IN-1; after j=N_IN-1 → WAIT_OUT.
  - WAIT_OUT: `valid_out`=1 → `result`←`feature`, → DONE.
  - DONE: `done`=1 one cycle → IDLE.
- `weight`/`data_in` drive 0 whenever their strobe is low.
- `start` outside IDLE ignored. `valid_out` outside WAIT_OUT ignored (no capture).
- `reset` mid-operation: immediate return to IDLE with reset values; FC block is expected to be reset alongside.

## Timing
- Cycle 0: IDLE samples `start`=1. Cycles 1..N_IN+1: weight stream (17 cycles at defaults, one word per cycle, no gaps). Cycle N_IN+2: first WAIT_WD cycle.
- `load_weight_done` seen high in WAIT_WD cycle t → GAP at t+1 → SEND t+2..t+N_IN+1 → WAIT_OUT from t+N_IN+2.
- With `reuse_w`=1: GAP at cycle 1, SEND cycles 2..N_IN+1.
- `valid_out` seen in WAIT_OUT cycle u → `result` updated and `done`=1 in cycle u+1; `busy` low and IDLE in cycle u+2; `start` accepted there.
- `valid_out` in the same cycle WAIT_OUT is entered is captured.

## Configuration
- `FC_FEEDER_TIMEOUT_EN` defined: a cycle counter runs in WAIT_WD and WAIT_OUT; reaching TIMEOUT cycles without the awaited input sets `err`=1, drops to IDLE without `done` (`result` unchanged, `busy` low next cycle).
- Not defined: wait states wait indefinitely; `err` tied 0; no counter logic.

## Test plan
- Load wmem=1..17, fmem=0x10..0x1F; `start` → `load_weight` high 17 consecutive cycles with weights 1..17, then `load_weight_done` after 3 cycles → one gap, 16 `valid_in` cycles carrying 0x10..0x1F in order.
- FC model returns `feature`=0xDEADBEEF 5 cycles into WAIT_OUT → `result`=0xDEADBEEF, `done` single pulse, `busy` deasserts next cycle.
- `reuse_w`=1 start → no `load_weight` cycle; `valid_in` begins cycle 2.
- Writes during `busy` (addr 0, data 0xFFFF) and `start` pulses during SEND → memory unchanged on next run, sequence not restarted.
- `reset` asserted in SEND at j=7 → next cycle all outputs 0, IDLE; fresh `start` replays full sequence.
- With `FC_FEEDER_TIMEOUT_EN`, TIMEOUT=32, `load_weight_done` never asserted → `err`=1 after 32 WAIT_WD cycles, no `done`, `valid_in` never asserted; next `start` clears `err`.
